// File: rtl/vga_fb_pixel_pipe.sv
// Framebuffer pixel source for the VGA output: a 1bpp 320x240 buffer shown pixel-doubled at 640x480
// with a two-entry palette. hsync/vsync travel with the pixel so all three outputs leave aligned.
module vga_fb_pixel_pipe #(
  parameter int H_VISIBLE      = 640,
  parameter int V_VISIBLE      = 480,
  parameter int WORDS_PER_LINE = 10,
  parameter int FB_WORDS       = 2400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  hcnt,
  input  logic [9:0]  vcnt,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        fb_we,
  input  logic [11:0] fb_waddr,
  input  logic [31:0] fb_wdata,
  input  logic        pal_we,
  input  logic        pal_sel,
  input  logic [11:0] pal_data,
  output logic [11:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        vblank_pulse
);

  localparam logic [9:0]  H_VIS     = 10'(H_VISIBLE);
  localparam logic [9:0]  V_VIS     = 10'(V_VISIBLE);
  localparam logic [11:0] ROW_WORDS = 12'(WORDS_PER_LINE);
  localparam logic [11:0] FB_DEPTH  = 12'(FB_WORDS);

  logic [31:0] fb_mem [FB_WORDS];

  logic [11:0] bg, fg;

  logic [11:0] addr_p0;
  logic [4:0]  idx_p0;
  logic        vld_p0;

  logic [11:0] addr_p1;
  logic [4:0]  idx_p1;
  logic        vld_p1, hs_p1, vs_p1;

  logic [31:0] word_p2;
  logic [4:0]  idx_p2;
  logic        vld_p2, hs_p2, vs_p2;

  function automatic logic [11:0] pixel_colour(input logic vld, input logic bit_on,
                                               input logic [11:0] bg_c, input logic [11:0] fg_c);
    if (!vld) return 12'h000;
    return bit_on ? fg_c : bg_c;
  endfunction

  // Stage 0: one framebuffer bit covers a 2x2 block of screen pixels
  always_comb begin
    addr_p0 = 12'(vcnt[9:1]) * ROW_WORDS + 12'(hcnt[9:6]);
    idx_p0  = hcnt[5:1];
    vld_p0  = (hcnt < H_VIS) && (vcnt < V_VIS);
  end

  // Stage 1: address, bit index, active and syncs registered
  always_ff @(posedge clk) begin
    addr_p1 <= addr_p0;
    idx_p1  <= idx_p0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      hs_p1  <= 1'b1;
      vs_p1  <= 1'b1;
    end else begin
      vld_p1 <= vld_p0;
      hs_p1  <= hsync_in;
      vs_p1  <= vsync_in;
    end
  end

  // Stage 2: RAM read data; a same-edge write to the word returns the old contents
  always_ff @(posedge clk) begin
    if (fb_we && (fb_waddr < FB_DEPTH))
      fb_mem[fb_waddr] <= fb_wdata;
    word_p2 <= fb_mem[addr_p1];
    idx_p2  <= idx_p1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      hs_p2  <= 1'b1;
      vs_p2  <= 1'b1;
    end else begin
      vld_p2 <= vld_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
    end
  end

  // Stage 3: output registers; the palette is used as-is, not aligned to the pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb   <= 12'h000;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      rgb   <= pixel_colour(vld_p2, word_p2[idx_p2], bg, fg);
      hsync <= hs_p2;
      vsync <= vs_p2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bg           <= 12'h000;
      fg           <= 12'h0ff;
      vblank_pulse <= 1'b0;
    end else begin
      if (pal_we) begin
        if (pal_sel) fg <= pal_data;
        else         bg <= pal_data;
      end
      vblank_pulse <= (vcnt == V_VIS) && (hcnt == 10'd0);
    end
  end

endmodule

// File: doc/vga_fb_pixel_pipe.md
# vga_fb_pixel_pipe

Pixel source stage placed directly upstream of the VGA output pins: takes the horizontal/vertical counts and sync strobes from the counter/sync stages and turns them into a 12-bit RGB pixel stream. Pixels come from an internal 1bpp 320x240 framebuffer, pixel-doubled to 640x480, with a two-entry palette. CPU writes go through a separate write port. Sync strobes are delayed to match the pixel pipeline latency, so hsync, vsync and rgb leave the block aligned.

## Interface
- H_VISIBLE, 640, visible pixels per line
- V_VISIBLE, 480, visible lines per frame
- WORDS_PER_LINE, 10, 32-bit framebuffer words per framebuffer row (320/32)
- FB_WORDS, 2400, framebuffer depth in words (10 x 240)

Ports:
- clk  in  1  25 MHz pixel clock
- rst  in  1  synchronous, active-high reset
- hcnt  in  10  horizontal count, 0..799
- vcnt  in  10  vertical count, 0..524
- hsync_in  in  1  active-low hsync, same cycle as hcnt/vcnt
- vsync_in  in  1  active-low vsync, same cycle as hcnt/vcnt
- fb_we  in  1  framebuffer write strobe
- fb_waddr  in  12  framebuffer word address
- fb_wdata  in  32  framebuffer word; bit 0 is the leftmost pixel
- pal_we  in  1  palette write strobe
- pal_sel  in  1  0 = background entry, 1 = foreground entry
- pal_data  in  12  palette colour, {R[3:0],G[3:0],B[3:0]}
- rgb  out  12  pixel colour
- hsync  out  1  delayed hsync_in
- vsync  out  1  delayed vsync_in
- vblank_pulse  out  1  one-cycle pulse at the start of vertical blanking

## Operation
- Active region: active = (hcnt < H_VISIBLE) && (vcnt < V_VISIBLE).
- Address generation (stage 0, combinational on the inputs):
  - word address = vcnt[9:1]*10 + hcnt[9:6], in the range 0..2399.
  - bit index = hcnt[5:1].
  - Each framebuffer pixel covers 2x2 screen pixels.
- The framebuffer is a simple dual-port RAM:
  - Synchronous read with a registered address.
  - Write port: a write is performed when fb_we=1 and fb_waddr < FB_WORDS. Writes with fb_waddr >= 2400 are dropped with no side effects.
  - Read-during-write to the same word returns the old data.
- Pipeline:
  - S1 registers the word address, bit index, active, hsync_in and vsync_in.
  - S2 gets the RAM data and carries bit index, active and syncs forward.
  - S3 registers the outputs:
    - rgb = active ? (word[idx] ? fg : bg) : 12'h000
    - hsync and vsync are the S2 copies.
- Palette:
  - Two 12-bit registers, bg and fg, written when pal_we=1 and selected by pal_sel.
  - Reset values: bg=12'h000, fg=12'h0ff.
  - A palette write in cycle N affects rgb registered at edge N+1 and later. No attempt is made to align palette writes to the pixel pipeline.
- vblank_pulse: registered, goes high for exactly one cycle, the cycle after the inputs show vcnt==V_VISIBLE && hcnt==0. It is not delayed by the pipeline. The CPU uses it as a safe-to-write indication.
- Reset:
  - rgb=12'h000, hsync=1, vsync=1, vblank_pulse=0.
  - All pipeline active/sync stages clear to inactive: active=0, syncs=1.
  - Palette returns to its reset values.
  - Framebuffer contents are not cleared.
  - Reset asserted mid-line kills all in-flight pixels. After rst deasserts, the first valid rgb appears 3 cycles after the first input cycle.

## Timing
- Latency from hcnt/vcnt/hsync_in/vsync_in at edge T to rgb/hsync/vsync valid after edge T+3 is 3 cycles, identical for all three outputs.
- Throughput is one pixel per clock with no stalls. The write port is always accepted; there is no ready/backpressure signal.
- Counter wrap-around (hcnt 799->0, vcnt 524->0) needs no special handling. Address generation is purely a function of the current counts.
- A framebuffer write in cycle N is visible to reads whose S1 address register loads at edge N+1 or later. A same-cycle collision returns the old data.
- At most 1 cycle of vblank_pulse per frame. Holding vcnt at 480 with hcnt=0 for several cycles keeps vblank_pulse high for the same number of cycles.

## Test plan
- Reset: hold rst for 5 cycles with arbitrary inputs -> rgb=000, hsync=1, vsync=1, vblank_pulse=0 on every cycle.
- Pixel doubling and bit order: write fb word 0 = 32'h00000001, then drive hcnt=0,1,2,3 with vcnt=0 -> rgb = 0ff, 0ff, 000, 000 three cycles later. Repeat with vcnt=1 for the same result, then vcnt=2 -> all 000.
- Addressing: write word 2399 = 32'h80000000, then drive vcnt=479, hcnt=638 -> rgb=0ff. hcnt=636 -> rgb=000.
- Palette: pal_we with pal_sel=1, pal_data=F00, and pal_sel=0, pal_data=00F. Word 0 = all ones gives rgb=F00 at hcnt=0. Word 1 = 0 gives rgb=00F at hcnt=64.
- Blanking and syncs: word data all ones, hcnt=640 or vcnt=480 -> rgb=000. hsync_in falling at edge T -> hsync falls after T+3. vsync_in likewise.
- Boundaries: a write to fb_waddr=2400 leaves words 0 and 2399 unchanged. vcnt=480, hcnt=0 gives a single-cycle vblank_pulse on the next cycle. Asserting rst mid-line forces rgb=000 on the next edge.
